// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the mm:ss countdown controller.
package countdown_ctrl_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int DIGIT_W  = 4;
  localparam int N_DIGITS = 4;

  // Digit indices, least significant first
  localparam logic [1:0] SEC0 = 2'd0;
  localparam logic [1:0] SEC1 = 2'd1;
  localparam logic [1:0] MIN0 = 2'd2;
  localparam logic [1:0] MIN1 = 2'd3;

  // One-hot select of a digit index
  function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    logic [N_DIGITS-1:0] oh;
    oh = {N_DIGITS{1'b0}};
    case (idx)
      SEC0:    oh = 4'b0001;
      SEC1:    oh = 4'b0010;
      MIN0:    oh = 4'b0100;
      MIN1:    oh = 4'b1000;
      default: oh = {N_DIGITS{1'b0}};
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Digit-chain protocol between the controller (master) and the BCD digit counters (slave).
interface countdown_ctrl_if;
  import countdown_ctrl_pkg::*;

  logic [N_DIGITS*DIGIT_W-1:0] digits;        // {min1,min0,sec1,sec0}
  logic                        borrow_top;    // borrow out of min1
  logic                        decrease;      // per-tick decrement into sec0
  logic [N_DIGITS-1:0]         increase_set;  // one-hot set increment

  modport master (
    input  digits,
    input  borrow_top,
    output decrease,
    output increase_set
  );

  modport slave (
    output digits,
    output borrow_top,
    input  decrease,
    input  increase_set
  );
endinterface

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler producing a registered one-cycle tick every TICK_DIV enabled cycles.
// Clear restarts the phase; a disabled prescaler holds its count so a resume keeps phase.
module countdown_ctrl_tick_gen #(
  parameter int TICK_DIV = 100,
  parameter int TICK_W   = 7
) (
  input  logic clk_out,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_r;
  logic              tick_r;

  // Prescaler count and tick register; clear dominates enable
  always_ff @(posedge clk_out) begin
    if (rst) begin
      cnt_r  <= {TICK_W{1'b0}};
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {TICK_W{1'b0}};
      tick_r <= 1'b0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r  <= {TICK_W{1'b0}};
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + TICK_W'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown control FSM for a four-digit mm:ss BCD counter chain.
// Issues the per-tick decrease and the set-mode increments, detects expiry and underflow.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int TICK_W   = 7
) (
  input  logic                    clk_out,
  input  logic                    rst,
  input  logic                    btn_start,
  input  logic                    btn_set,
  input  logic                    btn_inc,
  countdown_ctrl_if.master        dig_if,
  output logic [1:0]              sel_digit,
  output logic                    running,
  output logic                    done,
  output logic                    err
);

  state_e              state_r;
  state_e              next_state_s;
  logic                zero_s;
  logic                tick_en_s;
  logic                tick_clr_s;
  logic                tick_s;
  logic [1:0]          sel_nxt_s;
  logic [N_DIGITS-1:0] inc_s;
  logic                running_s;
  logic                done_s;

  logic [1:0]          sel_r;
  logic [N_DIGITS-1:0] inc_r;
  logic                running_r;
  logic                done_r;
  logic                err_r;

  assign zero_s = (dig_if.digits == {(N_DIGITS*DIGIT_W){1'b0}});

  // State register
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; underflow overrides every button, start beats set
  always_comb begin
    next_state_s = state_r;
    if (dig_if.borrow_top) begin
      next_state_s = ST_DONE;
    end else begin
      case (state_r)
        ST_IDLE, ST_SET: begin
          if (btn_start) begin
            next_state_s = zero_s ? ST_DONE : ST_RUN;
          end else if (btn_set) begin
            next_state_s = ST_SET;
          end else begin
            next_state_s = state_r;
          end
        end
        ST_RUN: begin
          // digits are only trusted once the counters have absorbed the last decrease
          if (btn_start) begin
            next_state_s = ST_PAUSE;
          end else if (zero_s && !dig_if.decrease) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (btn_start) begin
            next_state_s = ST_RUN;
          end else if (btn_set) begin
            next_state_s = ST_SET;
          end else begin
            next_state_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (btn_start || btn_set) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DONE;
          end
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: prescaler control, digit select, set increments and status
  always_comb begin
    // Prescaler runs only while staying in RUN, so leaving RUN drops a due tick
    tick_en_s  = (state_r == ST_RUN) && (next_state_s == ST_RUN);
    // A fresh start (not a resume) restarts the prescaler phase
    tick_clr_s = ((state_r == ST_IDLE) || (state_r == ST_SET)) && (next_state_s == ST_RUN);
    sel_nxt_s  = sel_r;
    inc_s      = {N_DIGITS{1'b0}};
    running_s  = (next_state_s == ST_RUN);
    done_s     = (next_state_s == ST_DONE);
    if (!dig_if.borrow_top && !btn_start) begin
      case (state_r)
        ST_IDLE: begin
          if (btn_set) begin
            sel_nxt_s = SEC0;
          end else begin
            sel_nxt_s = sel_r;
          end
        end
        ST_SET: begin
          if (btn_set) begin
            sel_nxt_s = sel_r + 2'd1;
          end else if (btn_inc) begin
            inc_s = digit_onehot(sel_r);
          end else begin
            sel_nxt_s = sel_r;
          end
        end
        default: sel_nxt_s = sel_r;
      endcase
    end else begin
      sel_nxt_s = sel_r;
    end
  end

  // Output registers; err is sticky until reset
  always_ff @(posedge clk_out) begin
    if (rst) begin
      sel_r     <= SEC0;
      inc_r     <= {N_DIGITS{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      sel_r     <= sel_nxt_s;
      inc_r     <= inc_s;
      running_r <= running_s;
      done_r    <= done_s;
      err_r     <= err_r | dig_if.borrow_top;
    end
  end

  countdown_ctrl_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk_out (clk_out),
    .rst     (rst),
    .en      (tick_en_s),
    .clr     (tick_clr_s),
    .tick    (tick_s)
  );

  assign dig_if.decrease     = tick_s;
  assign dig_if.increase_set = inc_r;
  assign sel_digit           = sel_r;
  assign running             = running_r;
  assign done                = done_r;
  assign err                 = err_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: vector table plus countdown and pause sequences.
module tb_countdown_ctrl;

  logic clk_out = 1'b0;
  logic rst;
  logic btn_start;
  logic btn_set;
  logic btn_inc;
  logic [1:0] sel_digit;
  logic running;
  logic done;
  logic err;
  logic model_en;

  int checks = 0;
  int errors = 0;

  countdown_ctrl_if dif ();

  countdown_ctrl #(
    .TICK_DIV (4),
    .TICK_W   (3)
  ) dut (
    .clk_out      (clk_out),
    .rst          (rst),
    .btn_start    (btn_start),
    .btn_set      (btn_set),
    .btn_inc      (btn_inc),
    .dig_if       (dif),
    .sel_digit    (sel_digit),
    .running      (running),
    .done         (done),
    .err          (err)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    logic        rst;
    logic        start;
    logic        set;
    logic        inc;
    logic [15:0] digits;
    logic        borrow;
    logic        e_running;
    logic        e_done;
    logic        e_err;
    logic [1:0]  e_sel;
    logic [3:0]  e_inc;
    logic        e_dec;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic r, input logic s, input logic t, input logic i,
                              input logic [15:0] d, input logic b,
                              input logic er, input logic ed, input logic ee,
                              input logic [1:0] es, input logic [3:0] ei, input logic edc);
    vec_t v;
    v.rst = r; v.start = s; v.set = t; v.inc = i; v.digits = d; v.borrow = b;
    v.e_running = er; v.e_done = ed; v.e_err = ee; v.e_sel = es; v.e_inc = ei; v.e_dec = edc;
    return v;
  endfunction

  // BCD decrement of mm:ss used by the digit-chain model
  function automatic logic [15:0] bcd_dec(input logic [15:0] x);
    logic [15:0] r;
    logic        borrow;
    r = x;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; the digit model applies a decrease seen in the cycle just ended
  task automatic step();
    logic d;
    d = dif.decrease;
    @(posedge clk_out);
    #1;
    if (model_en && (d === 1'b1)) begin
      dif.digits = bcd_dec(dif.digits);
    end
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
    dif.digits = 16'h0059; dif.borrow_top = 1'b0; model_en = 1'b0;

    //              rst  st   set  inc  digits    brw  run  done err  sel   inc      dec
    vecs[0]  = mk(1'b1,1'b1,1'b1,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b1,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b1,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0001,1'b0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0001,1'b0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0001,1'b0);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd1,4'b0000,1'b0);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd1,4'b0010,1'b0);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd1,4'b0000,1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd2,4'b0000,1'b0);
    vecs[13] = mk(1'b0,1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,2'd2,4'b0000,1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0,1'b1,1'b0,2'd2,4'b0000,1'b0);
    vecs[15] = mk(1'b0,1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,2'd2,4'b0000,1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[17] = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,2'd0,4'b0000,1'b0);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,2'd0,4'b0000,1'b0);
    vecs[19] = mk(1'b0,1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[20] = mk(1'b0,1'b1,1'b0,1'b0,16'h0059,1'b0,1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[21] = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0);
    vecs[22] = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b1,1'b0,1'b1,1'b1,2'd0,4'b0000,1'b0);
    vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b1,1'b1,2'd0,4'b0000,1'b0);
    vecs[24] = mk(1'b0,1'b1,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b1,2'd0,4'b0000,1'b0);
    vecs[25] = mk(1'b0,1'b0,1'b1,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b1,2'd0,4'b0000,1'b0);
    vecs[26] = mk(1'b1,1'b0,1'b0,1'b0,16'h0059,1'b0,1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0);

    for (int i = 0; i < 27; i++) begin
      rst = vecs[i].rst; btn_start = vecs[i].start; btn_set = vecs[i].set;
      btn_inc = vecs[i].inc; dif.digits = vecs[i].digits; dif.borrow_top = vecs[i].borrow;
      step();
      chk($sformatf("vec%0d running", i), 16'(running), 16'(vecs[i].e_running));
      chk($sformatf("vec%0d done", i), 16'(done), 16'(vecs[i].e_done));
      chk($sformatf("vec%0d err", i), 16'(err), 16'(vecs[i].e_err));
      chk($sformatf("vec%0d sel_digit", i), 16'(sel_digit), 16'(vecs[i].e_sel));
      chk($sformatf("vec%0d increase_set", i), 16'(dif.increase_set), 16'(vecs[i].e_inc));
      chk($sformatf("vec%0d decrease", i), 16'(dif.decrease), 16'(vecs[i].e_dec));
    end
    rst = 1'b0; btn_start = 1'b0; btn_set = 1'b0; btn_inc = 1'b0; dif.borrow_top = 1'b0;

    // Countdown from 00:02 with the digit model decrementing on each decrease
    dif.digits = 16'h0002;
    model_en = 1'b1;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("cd entry running", 16'(running), 16'd1);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("cd k%0d decrease", k), 16'(dif.decrease), 16'((k == 4) || (k == 8)));
      chk($sformatf("cd k%0d done", k), 16'(done), 16'(k >= 10));
      chk($sformatf("cd k%0d running", k), 16'(running), 16'(k < 10));
      chk($sformatf("cd k%0d increase_set", k), 16'(dif.increase_set), 16'd0);
    end
    model_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Pause at prescaler 2, hold 10 cycles, resume: decrease two cycles later
    dif.digits = 16'h0059;
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      chk($sformatf("pr run k%0d decrease", k), 16'(dif.decrease), 16'd0);
    end
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("pr paused running", 16'(running), 16'd0);
    chk("pr paused decrease", 16'(dif.decrease), 16'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("pr hold k%0d decrease", k), 16'(dif.decrease), 16'd0);
    end
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    chk("pr resume running", 16'(running), 16'd1);
    chk("pr resume decrease", 16'(dif.decrease), 16'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("pr resume+%0d decrease", k), 16'(dif.decrease), 16'(k == 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Control FSM that drives a chain of settable BCD digit counters: mm:ss, four digits, each with decrease / increase_set / borrow / over_set.
- Initiator side of the digit protocol. It issues the per-second decrease pulse to the seconds-units digit and the one-hot increase_set pulses to the digit being set.
- It watches the digit values and the top digit's borrow to detect expiry and underflow.
- Sits between the debounced pushbutton pulses and the digit counters; feeds mode/status LEDs.

Parameters:
- TICK_DIV, 100, clk_out cycles per countdown tick (1 s on hardware; small for simulation); minimum 2.
- TICK_W, 7, width of the prescaler counter; must satisfy 2**TICK_W >= TICK_DIV.

Ports:
- clk_out  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- btn_start  input  1  one-cycle pulse: start/pause toggle
- btn_set  input  1  one-cycle pulse: enter SET / advance selected digit
- btn_inc  input  1  one-cycle pulse: increment selected digit
- digits  input  16  current digit values {min1,min0,sec1,sec0}, BCD, 4 bits each
- borrow_top  input  1  borrow output of min1 digit
- decrease  output  1  one-cycle pulse to sec0 digit decrease input
- increase_set  output  4  one-hot increment pulse; bit3=min1 .. bit0=sec0
- sel_digit  output  2  index of digit being set (0=sec0 .. 3=min1)
- running  output  1  high in RUN
- done  output  1  high in DONE
- err  output  1  sticky underflow error

Behaviour:
- Clock and reset: one clock, clk_out. Reset rst is synchronous and active-high. In the reset cycle: state=IDLE, prescaler=0, sel_digit=0, err=0. All outputs are registered and go low/0 on reset.
- States: IDLE, SET, RUN, PAUSE, DONE.
- IDLE:
  - btn_set -> SET with sel_digit=0.
  - btn_start with digits!=0 -> RUN, prescaler cleared.
  - btn_start with digits==0 -> DONE.
- SET:
  - btn_inc -> increase_set[sel_digit] high for exactly one cycle, on the cycle after btn_inc.
  - btn_set -> sel_digit+1, wrapping 3->0.
  - btn_start -> RUN (or DONE if digits==0), sel_digit unchanged.
  - Digit wrap limits belong to the digit counters; this block does not limit increments.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. At count==TICK_DIV-1, decrease is high on the next cycle for one cycle.
  - The first decrease occurs TICK_DIV cycles after entering RUN.
  - btn_start -> PAUSE. The prescaler value is held, not cleared, so resume keeps phase.
  - digits==0 while decrease is low -> DONE on the next edge. Net effect: decrease at cycle N, digits zero at N+1, done=1 at N+2.
  - btn_set is ignored in RUN.
- PAUSE: no decrease, prescaler frozen. btn_start -> RUN. btn_set -> SET.
- DONE: done=1, no pulses. btn_start or btn_set -> IDLE.
- Simultaneous buttons: btn_start has priority over btn_set, which has priority over btn_inc. Only one action is taken per cycle.
- Never assert decrease and increase_set in the same cycle.
- Underflow: borrow_top high in any cycle sets err. err is cleared only by rst. The state is forced to DONE.
- Reset mid-RUN: a decrease pulse due in the same cycle is suppressed.
- Out-of-range BCD on digits (>9) is not checked; only the ==0 compare is used.

Decomposition:
- Shared package holds:
  - state enum: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4 (3 bits);
  - digit index constants SEC0..MIN1;
  - DIGIT_W=4, N_DIGITS=4.
- One sub-module, tick_gen: prescaler with enable and clear, emitting a one-cycle tick, parameterised by TICK_DIV/TICK_W.

Test Plan:
- Reset: hold rst 2 cycles with buttons active -> state IDLE, all outputs 0, err=0.
- Set: btn_set, then btn_inc x3, btn_set, btn_inc x1 -> increase_set pulses 4'b0001 x3 then 4'b0010 x1, each exactly 1 cycle; sel_digit ends at 1.
- Countdown (TICK_DIV=4): digits=16'h0002, btn_start, bench model decrements the digits.
  - Required: decrease at cycles 4 and 8 after entry.
  - Required: done=1 two cycles after the second decrease.
  - Required: no third decrease.
- Pause/resume (TICK_DIV=4): btn_start at prescaler=2, wait 10 cycles, btn_start -> no decrease while paused; next decrease 2 cycles after resume.
- Zero start: digits=0, btn_start -> DONE next cycle, decrease never asserted.
- Underflow: in RUN, pulse borrow_top -> err=1 and done=1 next cycle; err remains 1 through DONE->IDLE until rst.
